// File: rtl/iiitb_alu_seq.sv
// Sequencer that sweeps an external registered ALU through all eight opcodes
// with fixed operands and records which opcodes returned a wrong result.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; outputs hold the last sweep's result
// ST_ISSUE | op/A/B presented to the ALU, one cycle
// ST_WAIT  | WAIT_CYC cycles for the ALU result to settle into R
// ST_CHECK | R compared against the expected value for op
// ST_DONE  | one-cycle done pulse, busy still high
module iiitb_alu_seq #(
  parameter int WAIT_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic [7:0] R,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [2:0] op,
  output logic       busy,
  output logic       done,
  output logic [7:0] err_mask,
  output logic [3:0] err_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [1:0] WAIT_LD = 2'(WAIT_CYC - 1);

  state_t     state;
  logic [1:0] wait_cnt;
  logic [7:0] expected;

  always_comb begin
    expected = 8'h00;
    case (op)
      3'd0: expected = A + B;
      3'd1: expected = A - B;
      3'd2: expected = A & B;
      3'd3: expected = A | B;
      3'd4: expected = A ^ B;
      3'd5: expected = ~A;
      3'd6: expected = {A[6:0], 1'b0};
      3'd7: expected = {1'b0, A[7:1]};
      default: expected = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      A        <= 8'h00;
      B        <= 8'h00;
      op       <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_mask <= 8'h00;
      err_cnt  <= 4'd0;
      wait_cnt <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            A        <= a_in;
            B        <= b_in;
            op       <= 3'd0;
            err_mask <= 8'h00;
            err_cnt  <= 4'd0;
            busy     <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= WAIT_LD;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == 2'd0) begin
            state <= ST_CHECK;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_CHECK: begin
          if (R != expected) begin
            err_mask[op] <= 1'b1;
            err_cnt      <= err_cnt + 4'd1;
          end
          // op parks at 7 after the last check so it reads 7 until the next start
          if (op == 3'd7) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            op    <= op + 3'd1;
            state <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
